// File: rtl/rl_ram_1rw_lp.sv
// Single-port RAM with byte enables, optional output register and per-bank
// light-sleep: idle banks drop to SLEEP and stall the requester while waking.

module rl_ram_1rw_lp_bank #(
  parameter int SLEEP_IDLE  = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  output logic active,
  output logic sleep
);
  typedef enum logic [1:0] {ACTIVE, SLEEP, WAKE} state_t;

  localparam int IW = (SLEEP_IDLE > 1) ? $clog2(SLEEP_IDLE + 1) : 1;
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = (SLEEP_IDLE > 0) ? IW'(SLEEP_IDLE - 1) : '0;
  localparam logic [IW-1:0] IDLE_MAX  = IW'(SLEEP_IDLE);
  localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_CYCLES - 1);

  state_t state, nxt;
  logic [IW-1:0] idle;
  logic [WW-1:0] wcnt;

  // A request landing on the last idle cycle wins over the sleep transition.
  always_comb begin
    nxt = state;
    case (state)
      ACTIVE:  if (SLEEP_IDLE > 0 && !hit && idle == IDLE_LAST) nxt = SLEEP;
      SLEEP:   if (hit) nxt = WAKE;
      WAKE:    if (wcnt == '0) nxt = ACTIVE;
      default: nxt = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACTIVE;
      idle  <= '0;
      wcnt  <= '0;
    end else begin
      state <= nxt;
      case (state)
        ACTIVE: begin
          if (hit) idle <= '0;
          else if (idle != IDLE_MAX) idle <= idle + 1'b1;
        end
        SLEEP: if (hit) wcnt <= WAKE_LOAD;
        WAKE: begin
          if (wcnt != '0) wcnt <= wcnt - 1'b1;
          else idle <= '0;
        end
        default: ;
      endcase
    end
  end

  assign active = (state == ACTIVE);
  assign sleep  = (state == SLEEP);
endmodule

module rl_ram_1rw_lp #(
  parameter int ABITS       = 10,
  parameter int DBITS       = 32,
  parameter int BANKS       = 2,
  parameter int REG_OUT     = 0,
  parameter int SLEEP_IDLE  = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [ABITS-1:0]       addr_i,
  input  logic                   we_i,
  input  logic [(DBITS+7)/8-1:0] be_i,
  input  logic [DBITS-1:0]       din_i,
  output logic [DBITS-1:0]       dout_o,
  output logic                   dout_valid_o,
  output logic [BANKS-1:0]       bank_sleep_o
);
  localparam int SW     = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int STAGES = (REG_OUT != 0) ? 2 : 1;

  logic [SW-1:0]    sel;
  logic [BANKS-1:0] active, hit;
  logic             acc, wr, rd;
  logic [DBITS-1:0] mask;

  if (BANKS > 1) begin : g_sel
    assign sel = addr_i[ABITS-1 -: SW];
  end else begin : g_sel1
    assign sel = '0;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign hit[b] = req_i && (sel == SW'(b));
    rl_ram_1rw_lp_bank #(
      .SLEEP_IDLE (SLEEP_IDLE),
      .WAKE_CYCLES(WAKE_CYCLES)
    ) u_bank (
      .clk   (clk_i),
      .rst   (rst_i),
      .hit   (hit[b]),
      .active(active[b]),
      .sleep (bank_sleep_o[b])
    );
  end

  assign gnt_o = active[sel];
  assign acc   = req_i & gnt_o;
  assign wr    = acc & we_i;
  assign rd    = acc & ~we_i;

  always_comb begin
    mask = '0;
    for (int i = 0; i < DBITS; i++) mask[i] = be_i[i/8];
  end

  logic [DBITS-1:0] mem [2**ABITS];

  always_ff @(posedge clk_i) begin
    if (wr) mem[addr_i] <= (mem[addr_i] & ~mask) | (din_i & mask);
  end

  // Stage 1 captures the array word at the accepting edge; stage 2 is the
  // optional output register. Data only moves with valid so dout holds.
  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1][DBITS-1:0] data_pipe;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd;
      if (rd) data_pipe[1] <= mem[addr_i];
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
      end
    end
  end

  assign dout_o       = data_pipe[STAGES];
  assign dout_valid_o = vld_pipe[STAGES];
endmodule

// File: tb/tb_rl_ram_1rw_lp.sv
// Two configurations share one stimulus stream: A sleeps (latency 1), B never
// sleeps (latency 2, 20-bit data). A time-based bank model checks both.
module tb_rl_ram_1rw_lp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we;
  logic [5:0]  addr;
  logic [3:0]  be;
  logic [31:0] din;
  logic        gnt_a, gnt_b, dv_a, dv_b;
  logic [31:0] dout_a;
  logic [19:0] dout_b;
  logic [1:0]  slp_a;
  logic [3:0]  slp_b;

  rl_ram_1rw_lp #(.ABITS(6), .DBITS(32), .BANKS(2), .REG_OUT(0),
                  .SLEEP_IDLE(4), .WAKE_CYCLES(2)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_a), .addr_i(addr),
    .we_i(we), .be_i(be), .din_i(din), .dout_o(dout_a),
    .dout_valid_o(dv_a), .bank_sleep_o(slp_a));

  rl_ram_1rw_lp #(.ABITS(6), .DBITS(20), .BANKS(4), .REG_OUT(1),
                  .SLEEP_IDLE(0), .WAKE_CYCLES(1)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_b), .addr_i(addr),
    .we_i(we), .be_i(be[2:0]), .din_i(din[19:0]), .dout_o(dout_b),
    .dout_valid_o(dv_b), .bank_sleep_o(slp_b));

  int total = 0, bad = 0, t = 0;
  int lat[2]   = '{1, 2};
  int si[2]    = '{4, 0};
  int wk[2]    = '{2, 1};
  int nbk[2]   = '{2, 4};
  int dw[2]    = '{32, 20};
  int shift[2] = '{5, 4};

  // Bank state from times: asleep once SLEEP_IDLE cycles have passed since
  // ref_t; unusable before wake_until.
  logic [31:0] mm [2][64];
  int          ref_t [2][4];
  int          wake_until [2][4];
  logic        ev [2][4];
  logic [31:0] ed [2][4];
  logic [31:0] exp_dout [2];

  function automatic bit m_sleep(int d, int b);
    return t >= wake_until[d][b] && si[d] > 0 && (t - ref_t[d][b]) >= si[d];
  endfunction

  function automatic bit m_gnt(int d, int b);
    return t >= wake_until[d][b] && !m_sleep(d, b);
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0d got=%h exp=%h", nm, t, a, e);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int d = 0; d < 2; d++) begin
      exp_dout[d] = '0;
      for (int k = 0; k < 4; k++) begin
        ref_t[d][k] = 0; wake_until[d][k] = 0; ev[d][k] = 1'b0; ed[d][k] = '0;
      end
    end
  endtask

  task automatic check_cycle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int b = int'(addr) >> shift[d];
      int s = t % 4;
      logic [3:0] es = '0;
      if (ev[d][s]) exp_dout[d] = ed[d][s];
      for (int k = 0; k < nbk[d]; k++) es[k] = m_sleep(d, k);
      if (d == 0) begin
        chk("gnt_a", {31'b0, gnt_a}, {31'b0, m_gnt(0, b)});
        chk("dv_a", {31'b0, dv_a}, {31'b0, ev[0][s]});
        chk("dout_a", dout_a, exp_dout[0]);
        chk("sleep_a", {30'b0, slp_a}, {28'b0, es});
      end else begin
        chk("gnt_b", {31'b0, gnt_b}, {31'b0, m_gnt(1, b)});
        chk("dv_b", {31'b0, dv_b}, {31'b0, ev[1][s]});
        chk("dout_b", {12'b0, dout_b}, exp_dout[1]);
        chk("sleep_b", {28'b0, slp_b}, {28'b0, es});
      end
      ev[d][s] = 1'b0;
    end
  endtask

  task automatic update_cycle(output bit acc);
    acc = 1'b0;
    for (int d = 0; d < 2; d++) begin
      int b = int'(addr) >> shift[d];
      if (req) begin
        if (m_sleep(d, b)) begin
          wake_until[d][b] = t + wk[d] + 1;
          ref_t[d][b]      = wake_until[d][b];
        end else if (m_gnt(d, b)) begin
          if (d == 0) acc = 1'b1;
          if (we) begin
            for (int i = 0; i < dw[d]; i++) if (be[i/8]) mm[d][addr][i] = din[i];
          end else begin
            ev[d][(t + lat[d]) % 4] = 1'b1;
            ed[d][(t + lat[d]) % 4] = mm[d][addr];
          end
          ref_t[d][b] = t + 1;
        end
      end
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        req, we;
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] din;
    logic        g, v;
    logic [31:0] q;
    logic [1:0]  s;
  } vec_t;

  function automatic vec_t mk(logic rq, logic w, logic [5:0] a, logic [3:0] e,
                              logic [31:0] dd, logic g, logic v, logic [31:0] q,
                              logic [1:0] s);
    vec_t r;
    r.req = rq; r.we = w; r.addr = a; r.be = e; r.din = dd;
    r.g = g; r.v = v; r.q = q; r.s = s;
    return r;
  endfunction

  initial begin
    vec_t tbl[16];
    bit   acc, stall;
    int   n;
    localparam logic [31:0] BEW = 32'hFF34FF78;
    localparam logic [31:0] WKD = 32'hA5A55A5A;

    // Directed run for config A, cycles counted from reset release.
    tbl[0]  = mk(1, 1, 5, 4'hF, 32'hFFFFFFFF, 1, 0, 0, 2'b00);
    tbl[1]  = mk(1, 1, 5, 4'h5, 32'h12345678, 1, 0, 0, 2'b00);
    tbl[2]  = mk(1, 0, 5, 4'hF, 0, 1, 0, 0, 2'b00);
    tbl[3]  = mk(0, 0, 5, 4'hF, 0, 1, 1, BEW, 2'b00);
    tbl[4]  = mk(0, 0, 5, 4'hF, 0, 1, 0, BEW, 2'b10);
    tbl[5]  = mk(0, 0, 5, 4'hF, 0, 1, 0, BEW, 2'b10);
    tbl[6]  = mk(1, 1, 7, 4'hF, WKD, 1, 0, BEW, 2'b10);
    tbl[7]  = mk(0, 0, 7, 4'hF, 0, 1, 0, BEW, 2'b10);
    tbl[8]  = mk(0, 0, 7, 4'hF, 0, 1, 0, BEW, 2'b10);
    tbl[9]  = mk(0, 0, 7, 4'hF, 0, 1, 0, BEW, 2'b10);
    tbl[10] = mk(0, 0, 7, 4'hF, 0, 1, 0, BEW, 2'b10);
    tbl[11] = mk(1, 0, 7, 4'hF, 0, 0, 0, BEW, 2'b11);
    tbl[12] = mk(1, 0, 7, 4'hF, 0, 0, 0, BEW, 2'b10);
    tbl[13] = mk(1, 0, 7, 4'hF, 0, 0, 0, BEW, 2'b10);
    tbl[14] = mk(1, 0, 7, 4'hF, 0, 1, 0, BEW, 2'b10);
    tbl[15] = mk(0, 0, 7, 4'hF, 0, 1, 1, WKD, 2'b10);

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 64; a++) mm[d][a] = '0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Fill the whole array so later reads have known contents.
    for (int a = 0; a < 64; a++) begin
      req = 1'b1; we = 1'b1; addr = 6'(a); be = 4'hF; din = $urandom;
      n = 0;
      do begin
        check_cycle();
        update_cycle(acc);
        n++;
      end while (!acc && n < 10);
      if (!acc) chk("init_grant_timeout", 32'd0, 32'd1);
    end
    req = 1'b0;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; we = tbl[i].we; addr = tbl[i].addr;
      be = tbl[i].be; din = tbl[i].din;
      check_cycle();
      chk($sformatf("tbl%0d_gnt", i), {31'b0, gnt_a}, {31'b0, tbl[i].g});
      chk($sformatf("tbl%0d_dv", i), {31'b0, dv_a}, {31'b0, tbl[i].v});
      chk($sformatf("tbl%0d_dout", i), dout_a, tbl[i].q);
      chk($sformatf("tbl%0d_sleep", i), {30'b0, slp_a}, {30'b0, tbl[i].s});
      update_cycle(acc);
    end

    // Wake bank 1 of A while B has reads in flight, then reset mid-wake.
    req = 1'b1; we = 1'b0; addr = 6'd40; be = 4'hF;
    check_cycle(); update_cycle(acc);
    check_cycle(); update_cycle(acc);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gnt_a", {31'b0, gnt_a}, 32'd1);
    chk("rst_dv_a", {31'b0, dv_a}, 32'd0);
    chk("rst_dout_a", dout_a, 32'd0);
    chk("rst_sleep_a", {30'b0, slp_a}, 32'd0);
    chk("rst_dv_b", {31'b0, dv_b}, 32'd0);
    chk("rst_dout_b", {12'b0, dout_b}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_cycle();
      chk("post_rst_dv_b", {31'b0, dv_b}, 32'd0);
      update_cycle(acc);
    end

    stall = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!stall) begin
        int rate = ((c / 60) % 2) != 0 ? 15 : 60;
        req  = ($urandom_range(0, 99) < rate);
        we   = 1'($urandom_range(0, 1));
        addr = 6'($urandom_range(0, 63));
        be   = 4'($urandom_range(0, 15));
        din  = $urandom;
      end
      check_cycle();
      update_cycle(acc);
      stall = req && !acc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
